// File: rtl/stage_renorm.sv
// rtl/stage_renorm.sv - AV1 encoder renormalization stage: low/range/cnt state, pre-carry bytes, end-of-frame flush.
// Optional out_err sticky flag for non-normalizable ranges when RENORM_ERR_FLAG_EN is defined.
module stage_renorm #(
  parameter int RANGE_WIDTH = 16,
  parameter int D_SIZE      = 4,
  parameter int LOW_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RANGE_WIDTH-1:0] in_range,
  input  logic [D_SIZE-1:0]      in_d,
  input  logic [RANGE_WIDTH-1:0] in_low_inc,
  input  logic                   in_flush,
  input  logic                   in_init,
  output logic [RANGE_WIDTH-1:0] out_range,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_num,
  output logic [8:0]             out_byte_0,
  output logic [8:0]             out_byte_1,
  output logic                   out_done
`ifdef RENORM_ERR_FLAG_EN
  ,
  output logic                   out_err
`endif
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [RANGE_WIDTH-1:0] RANGE_INIT = RANGE_WIDTH'(1) << (RANGE_WIDTH - 1);
  localparam logic signed [5:0]      CNT_INIT   = -6'sd9;
  localparam logic [LOW_WIDTH-1:0]   LOW_RND    = LOW_WIDTH'(32'h3FFF);
  localparam logic [LOW_WIDTH-1:0]   LOW_HALF   = LOW_WIDTH'(32'h4000);

  function automatic logic [LOW_WIDTH-1:0] low_mask(input logic [5:0] sh);
    return (LOW_WIDTH'(1) << sh) - LOW_WIDTH'(1);
  endfunction

  state_t                  r_state, w_state_nxt;
  logic [LOW_WIDTH-1:0]    r_low, r_e;
  logic [RANGE_WIDTH-1:0]  r_range;
  logic signed [5:0]       r_cnt, r_fc, r_fs;
  logic                    r_flush_req;
  logic                    r_out_valid;
  logic [1:0]              r_out_num;
  logic [8:0]              r_b0, r_b1;

  logic w_out_free, w_flush_any, w_accept, w_flush_go, w_fstep, w_fend;

  assign w_out_free  = !r_out_valid | out_ready;
  assign w_flush_any = in_flush | r_flush_req;
  // A pending flush request blocks symbol acceptance so flush wins over in_valid.
  assign in_ready    = (r_state == S_RUN) & w_out_free & !w_flush_any;
  assign w_accept    = in_valid & in_ready;
  assign w_flush_go  = (r_state == S_RUN) & w_flush_any & w_out_free;
  assign w_fstep     = (r_state == S_FLUSH) & w_out_free & (r_fs > 6'sd0);
  assign w_fend      = (r_state == S_FLUSH) & w_out_free & (r_fs <= 6'sd0);

  logic [LOW_WIDTH-1:0]   w_l, w_low_nxt;
  logic [RANGE_WIDTH-1:0] w_range_nxt;
  logic signed [5:0]      w_s, w_c, w_d;
  logic [1:0]             w_nb;
  logic [8:0]             w_sb0, w_sb1, w_bx;

  always_comb begin
    w_d   = $signed(6'(in_d));
    w_l   = r_low + LOW_WIDTH'(in_low_inc);
    w_s   = r_cnt + w_d;
    w_c   = '0;
    w_nb  = 2'd0;
    w_sb0 = '0;
    w_sb1 = '0;
    w_bx  = '0;
    if (w_s >= 6'sd0) begin
      w_c = r_cnt + 6'sd16;
      if (w_s >= 6'sd8) begin
        w_sb0 = 9'(w_l >> w_c);
        w_l   = w_l & low_mask(w_c);
        w_c   = w_c - 6'sd8;
        w_nb  = 2'd1;
      end
      w_bx = 9'(w_l >> w_c);
      w_l  = w_l & low_mask(w_c);
      if (w_nb == 2'd1) w_sb1 = w_bx;
      else              w_sb0 = w_bx;
      w_nb = w_nb + 2'd1;
      w_s  = w_c + w_d - 6'sd24;
    end
    w_low_nxt   = w_l << in_d;
    w_range_nxt = in_range << in_d;
  end

  logic [5:0]           w_fsh;
  logic [8:0]           w_fbyte;
  logic [LOW_WIDTH-1:0] w_e_nxt, w_e_init;

  assign w_fsh    = 6'(r_fc + 6'sd16);
  assign w_fbyte  = 9'(r_e >> w_fsh);
  assign w_e_nxt  = r_e & low_mask(w_fsh);
  assign w_e_init = ((r_low + LOW_RND) & ~LOW_RND) | LOW_HALF;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (w_flush_go) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_fend)     w_state_nxt = S_DONE;
      S_DONE:  if (in_init)    w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_RUN;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_low       <= '0;
      r_range     <= RANGE_INIT;
      r_cnt       <= CNT_INIT;
      r_e         <= '0;
      r_fc        <= '0;
      r_fs        <= '0;
      r_flush_req <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_num   <= 2'd0;
      r_b0        <= '0;
      r_b1        <= '0;
    end else begin
      if (w_accept) begin
        r_low       <= w_low_nxt;
        r_range     <= w_range_nxt;
        r_cnt       <= w_s;
        r_out_valid <= (w_nb != 2'd0);
        r_out_num   <= w_nb;
        r_b0        <= w_sb0;
        r_b1        <= w_sb1;
      end else if (w_flush_go) begin
        r_out_valid <= 1'b0;
        r_e         <= w_e_init;
        r_fc        <= r_cnt;
        r_fs        <= r_cnt + 6'sd10;
        r_flush_req <= 1'b0;
      end else if (w_fstep) begin
        r_out_valid <= 1'b1;
        r_out_num   <= 2'd1;
        r_b0        <= w_fbyte;
        r_b1        <= '0;
        r_e         <= w_e_nxt;
        r_fc        <= r_fc - 6'sd8;
        r_fs        <= r_fs - 6'sd8;
      end else if (r_out_valid & out_ready) begin
        r_out_valid <= 1'b0;
      end
      // Flush seen while the output is stalled is remembered until it drains.
      if ((r_state == S_RUN) & in_flush & !w_out_free) r_flush_req <= 1'b1;
      if ((r_state == S_DONE) & in_init) begin
        r_low   <= '0;
        r_range <= RANGE_INIT;
        r_cnt   <= CNT_INIT;
      end
    end
  end

  assign out_range  = r_range;
  assign out_valid  = r_out_valid;
  assign out_num    = r_out_num;
  assign out_byte_0 = r_b0;
  assign out_byte_1 = r_b1;
  assign out_done   = (r_state == S_DONE);

`ifdef RENORM_ERR_FLAG_EN
  logic w_bad;
  logic r_err;
  assign w_bad = (in_range == '0) | !w_range_nxt[RANGE_WIDTH-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           r_err <= 1'b0;
    else if ((r_state == S_DONE) & in_init) r_err <= 1'b0;
    else if (w_accept & w_bad)              r_err <= 1'b1;
  end

  assign out_err = r_err;
`endif

endmodule

// File: tb/tb_stage_renorm.sv
// tb/tb_stage_renorm.sv - self-checking bench for stage_renorm against a queue-based reference model.
module tb_stage_renorm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_flush = 1'b0, in_init = 1'b0, out_ready = 1'b0;
  logic [15:0] in_range = '0, in_low_inc = '0;
  logic [3:0]  in_d = '0;
  logic        in_ready, out_valid, out_done;
  logic [15:0] out_range;
  logic [1:0]  out_num;
  logic [8:0]  out_byte_0, out_byte_1;
`ifdef RENORM_ERR_FLAG_EN
  logic        out_err;
`endif

  stage_renorm dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_range(in_range), .in_d(in_d), .in_low_inc(in_low_inc), .in_flush(in_flush),
    .in_init(in_init), .out_range(out_range), .out_valid(out_valid), .out_ready(out_ready),
    .out_num(out_num), .out_byte_0(out_byte_0), .out_byte_1(out_byte_1), .out_done(out_done)
`ifdef RENORM_ERR_FLAG_EN
    , .out_err(out_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference state; each queued transaction is {num[1:0], byte0[8:0], byte1[8:0]}.
  longint      m_low;
  int          m_cnt;
  int          m_range;
  logic [19:0] m_q[$];
  bit          run_chk = 1'b0;
  int          xfers = 0;

  function automatic void m_reset();
    m_low = 0; m_cnt = -9; m_range = 'h8000;
  endfunction

  function automatic void m_step(int rng, int d, int inc);
    longint l = m_low + inc;
    int s = m_cnt + d;
    int c;
    int b[$];
    if (s >= 0) begin
      c = m_cnt + 16;
      if (s >= 8) begin
        b.push_back(int'((l >> c) & 'h1FF));
        l = l & ((64'd1 << c) - 1);
        c -= 8;
      end
      b.push_back(int'((l >> c) & 'h1FF));
      l = l & ((64'd1 << c) - 1);
      s = c + d - 24;
    end
    m_low = (l << d) & 64'hFFFF_FFFF;
    m_cnt = s;
    m_range = (rng << d) & 'hFFFF;
    if (b.size() == 1) m_q.push_back({2'd1, 9'(b[0]), 9'd0});
    else if (b.size() == 2) m_q.push_back({2'd2, 9'(b[0]), 9'(b[1])});
  endfunction

  function automatic void m_flush();
    longint e = ((m_low + 'h3FFF) & ~64'h3FFF) | 'h4000;
    int c = m_cnt;
    int s = m_cnt + 10;
    while (s > 0) begin
      m_q.push_back({2'd1, 9'((e >> (c + 16)) & 'h1FF), 9'd0});
      e = e & ((64'd1 << (c + 16)) - 1);
      s -= 8;
      c -= 8;
    end
  endfunction

  task automatic tick();
    logic        acc, xf;
    logic [19:0] p;
    @(negedge clk);
    acc = in_valid & in_ready;
    xf  = out_valid & out_ready;
    if (run_chk) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, (m_q.size() == 0 || out_ready) && !in_flush});
    end
    if (xf) begin
      xfers++;
      if (m_q.size() == 0) check("unexpected_xfer", {31'd0, out_valid}, 32'd0);
      else begin
        p = m_q.pop_front();
        check("out_num", {30'd0, out_num}, {30'd0, p[19:18]});
        check("byte0", {23'd0, out_byte_0}, {23'd0, p[17:9]});
        if (p[19:18] == 2'd2) check("byte1", {23'd0, out_byte_1}, {23'd0, p[8:0]});
      end
    end
    if (acc) m_step(int'(in_range), int'(in_d), int'(in_low_inc));
    @(posedge clk);
    #1;
    if (acc) check("out_range", {16'd0, out_range}, m_range);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_flush = 1'b0; in_init = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_reset();
    m_q.delete();
  endtask

  task automatic sym(input logic [15:0] r, input logic [3:0] d, input logic [15:0] inc);
    in_valid = 1'b1; in_range = r; in_d = d; in_low_inc = inc;
  endtask

  task automatic rand_sym();
    logic [15:0] r;
    logic [3:0]  d;
    r = 16'($urandom_range(1, 'hFFFF));
    d = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (r[i]) break;
      d = d + 4'd1;
    end
    sym(r, d, 16'($urandom));
  endtask

  task automatic do_flush(input bit rnd);
    int n;
    run_chk = 1'b0; in_valid = 1'b0; in_flush = 1'b1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    m_flush();
    n = m_q.size();
    xfers = 0;
    tick();
    in_flush = 1'b0;
    for (int i = 0; i < 60 && !out_done; i++) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    check("flush_done", {31'd0, out_done}, 32'd1);
    check("flush_xfers", xfers, n);
  endtask

  task automatic do_init();
    in_init = 1'b1;
    tick();
    in_init = 1'b0;
    m_reset();
  endtask

  initial begin
    do_reset();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_num", {30'd0, out_num}, 32'd0);
    check("rst_b0", {23'd0, out_byte_0}, 32'd0);
    check("rst_b1", {23'd0, out_byte_1}, 32'd0);
    check("rst_done", {31'd0, out_done}, 32'd0);
    check("rst_range", {16'd0, out_range}, 32'h8000);
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    run_chk = 1'b1; out_ready = 1'b1;
    sym(16'h4000, 4'd1, 16'h0000); tick(); in_valid = 1'b0;
    check("t1_valid", {31'd0, out_valid}, 32'd0);
    check("t1_range", {16'd0, out_range}, 32'h8000);

    do_reset();
    out_ready = 1'b0;
    sym(16'h0040, 4'd9, 16'hFFFF); tick();
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_num", {30'd0, out_num}, 32'd1);
    check("t2_b0", {23'd0, out_byte_0}, 32'h1FF);
    rand_sym();
    repeat (5) begin
      tick();
      check("hold_ready", {31'd0, in_ready}, 32'd0);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_b0", {23'd0, out_byte_0}, 32'h1FF);
    end
    in_valid = 1'b0; out_ready = 1'b1; xfers = 0;
    tick();
    check("release_xfers", xfers, 1);
    check("release_valid", {31'd0, out_valid}, 32'd0);
    do_flush(1'b0);

    do_reset();
    run_chk = 1'b1; out_ready = 1'b1;
    sym(16'h0080, 4'd8, 16'h0000); tick();
    check("t3a_valid", {31'd0, out_valid}, 32'd0);
    sym(16'h0040, 4'd9, 16'h0000); tick(); in_valid = 1'b0;
    check("t3_num", {30'd0, out_num}, 32'd2);
    check("t3_b0", {23'd0, out_byte_0}, 32'h000);
    check("t3_b1", {23'd0, out_byte_1}, 32'h000);
    tick();

    do_reset();
    out_ready = 1'b1;
    do_flush(1'b0);
    do_init();
    check("init_done", {31'd0, out_done}, 32'd0);
    check("init_range", {16'd0, out_range}, 32'h8000);
    check("init_ready", {31'd0, in_ready}, 32'd1);
    run_chk = 1'b1;
    sym(16'h0080, 4'd8, 16'h0000); tick(); in_valid = 1'b0;
    check("init_cnt", {31'd0, out_valid}, 32'd0);

    do_reset();
    run_chk = 1'b1; out_ready = 1'b1;
    repeat (10) begin rand_sym(); tick(); end
    run_chk = 1'b0; in_valid = 1'b0; in_flush = 1'b1;
    tick();
    in_flush = 1'b0; out_ready = 1'b0;
    tick();
    check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_valid", {31'd0, out_valid}, 32'd0);
    check("t6_num", {30'd0, out_num}, 32'd0);
    check("t6_b0", {23'd0, out_byte_0}, 32'd0);
    check("t6_done", {31'd0, out_done}, 32'd0);
    check("t6_range", {16'd0, out_range}, 32'h8000);
    m_q.delete(); m_reset();
    @(posedge clk); #1 reset_n = 1'b1;

    for (int f = 0; f < 3; f++) begin
      run_chk = 1'b1;
      repeat (150) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) != 0) rand_sym();
        else in_valid = 1'b0;
        tick();
      end
      do_flush(1'b1);
      do_init();
    end

`ifdef RENORM_ERR_FLAG_EN
    do_reset();
    out_ready = 1'b1;
    check("err_rst", {31'd0, out_err}, 32'd0);
    sym(16'h0000, 4'd0, 16'h0000); tick(); in_valid = 1'b0;
    check("err_set", {31'd0, out_err}, 32'd1);
    tick();
    check("err_sticky", {31'd0, out_err}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
